// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, req/ack instruction-memory fetch and a DEPTH-entry decode queue.
// Optional FETCH_ALIGN_TRAP_EN: misaligned redirects raise fetch_fault and halt fetch instead of being aligned.
module fetch_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter int unsigned     ILEN         = 32,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        HALT
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             fault_q, fault_d;
    logic [ILEN-1:0]  mem_inst_q [DEPTH];
    logic [XLEN-1:0]  mem_pc_q   [DEPTH];
    logic [XLEN-1:0]  target_pc;
    logic             misaligned;
    logic             push;
    logic             pop;

`ifdef FETCH_ALIGN_TRAP_EN
    assign target_pc  = redirect_pc;
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign target_pc  = redirect_pc & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

    assign push = (state_q == WAIT) && imem_ack && !redirect;
    assign pop  = (count_q != '0) && inst_ready && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            if (misaligned) begin
                state_d = HALT;
            end else if ((state_q == WAIT || state_q == DROP) && !imem_ack) begin
                state_d = DROP;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                // A pop this cycle frees a slot, so the request can start on the next edge.
                IDLE:    if (count_q < DEPTH_C || pop) state_d = WAIT;
                WAIT:    if (imem_ack) state_d = (count_q + CNT_W'(1) < DEPTH_C) ? WAIT : IDLE;
                DROP:    if (imem_ack) state_d = IDLE;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req   = (state_q == WAIT) || (state_q == DROP);
        imem_addr  = addr_q;
        inst_valid = (count_q != '0);
        inst_data  = inst_valid ? mem_inst_q[rd_ptr_q] : '0;
        inst_pc    = inst_valid ? mem_pc_q[rd_ptr_q] : '0;
        fetch_fault = fault_q;
    end

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fault_d  = fault_q;
        if (redirect) begin
            pc_d     = target_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fault_d  = misaligned;
        end else begin
            if (push) begin
                pc_d     = pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        // DROP keeps presenting the stale address; pc already holds the redirect target.
        addr_d = (state_d == DROP || state_d == HALT) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            addr_q   <= RESET_VECTOR;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fault_q  <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters; trap section follows FETCH_ALIGN_TRAP_EN).
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        tick; tick;
        check("rst_req",   imem_req,    64'd0);
        check("rst_addr",  imem_addr,   64'd0);
        check("rst_valid", inst_valid,  64'd0);
        check("rst_data",  inst_data,   64'd0);
        check("rst_pc",    inst_pc,     64'd0);
        check("rst_fault", fetch_fault, 64'd0);

        // first request right after reset release, ack one cycle later
        reset = 1'b1;
        tick;
        check("first_req",  imem_req,  64'd1);
        check("first_addr", imem_addr, 64'h0);
        tick;
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick;
        imem_ack = 1'b0; inst_ready = 1'b1;
        check("seq0_valid", inst_valid, 64'd1);
        check("seq0_pc",    inst_pc,    64'h0);
        check("seq0_data",  inst_data,  64'h1111_1111);
        check("seq0_req",   imem_req,   64'd1);
        check("seq0_addr",  imem_addr,  64'h4);
        tick;
        check("seq_empty_valid", inst_valid, 64'd0);
        check("seq_empty_data",  inst_data,  64'd0);
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        tick;
        imem_ack = 1'b0;
        check("seq1_pc",   inst_pc,   64'h4);
        check("seq1_data", inst_data, 64'h2222_2222);
        check("seq1_addr", imem_addr, 64'h8);
        tick;
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        tick;
        imem_ack = 1'b0;
        check("seq2_pc",   inst_pc,   64'h8);
        check("seq2_data", inst_data, 64'h3333_3333);
        check("seq2_addr", imem_addr, 64'hC);

        // asynchronous reset mid-operation
        reset = 1'b0; inst_ready = 1'b0;
        #1;
        check("midrst_req",   imem_req,   64'd0);
        check("midrst_addr",  imem_addr,  64'd0);
        check("midrst_valid", inst_valid, 64'd0);
        tick;
        reset = 1'b1;
        tick;
        check("refetch_req",  imem_req,  64'd1);
        check("refetch_addr", imem_addr, 64'h0);

        // fill the queue with ack every cycle and no pops
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'hB000_0000 + 32'(i);
            tick;
            check("fill_req",  imem_req,  (i < 3) ? 64'd1 : 64'd0);
            check("fill_addr", imem_addr, 64'(4 * (i + 1)));
        end
        imem_rdata = 32'h0BAD_0BAD;
        tick;
        check("full_req",   imem_req,   64'd0);
        check("full_valid", inst_valid, 64'd1);
        check("full_pc",    inst_pc,    64'h0);
        check("full_data",  inst_data,  64'hB000_0000);
        imem_ack = 1'b0; inst_ready = 1'b1;
        tick;
        inst_ready = 1'b0;
        check("pop_req",  imem_req,  64'd1);
        check("pop_addr", imem_addr, 64'h10);
        check("pop_pc",   inst_pc,   64'h4);
        check("pop_data", inst_data, 64'hB000_0001);

        // redirect while waiting: stale request held, response discarded
        redirect = 1'b1; redirect_pc = 64'h100;
        tick;
        redirect = 1'b0;
        check("drop_valid", inst_valid, 64'd0);
        check("drop_data",  inst_data,  64'd0);
        check("drop_req",   imem_req,   64'd1);
        check("drop_addr",  imem_addr,  64'h10);
        tick; tick;
        check("drop_hold_req",  imem_req,  64'd1);
        check("drop_hold_addr", imem_addr, 64'h10);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick;
        imem_ack = 1'b0;
        check("stale_valid", inst_valid, 64'd0);
        check("stale_data",  inst_data,  64'd0);
        check("stale_req",   imem_req,   64'd0);
        tick;
        check("redir_req",   imem_req,   64'd1);
        check("redir_addr",  imem_addr,  64'h100);
        check("redir_valid", inst_valid, 64'd0);

        // redirect coincident with ack and pop
        imem_ack = 1'b1; imem_rdata = 32'hC000_0000;
        tick;
        check("co_pre_pc",   inst_pc,   64'h100);
        check("co_pre_data", inst_data, 64'hC000_0000);
        check("co_pre_addr", imem_addr, 64'h104);
        imem_rdata = 32'hC000_0001; inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 64'h2000;
        tick;
        imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        check("co_valid", inst_valid, 64'd0);
        check("co_data",  inst_data,  64'd0);
        check("co_pc",    inst_pc,    64'd0);
        check("co_req",   imem_req,   64'd0);
        tick;
        check("co_next_req",  imem_req,  64'd1);
        check("co_next_addr", imem_addr, 64'h2000);

        // PC wrap at the top of the address space
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick;
        imem_ack = 1'b0; redirect = 1'b0;
        check("wrap_idle_req", imem_req, 64'd0);
        tick;
        check("wrap_req",  imem_req,  64'd1);
        check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
        tick;
        imem_ack = 1'b0;
        check("wrap_next_addr", imem_addr, 64'h0);
        check("wrap_next_req",  imem_req,  64'd1);
        check("wrap_pc",        inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_data",      inst_data, 64'hE000_0000);

        // misaligned redirect
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 64'h102;
        tick;
        imem_ack = 1'b0; redirect = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
        check("trap_fault", fetch_fault, 64'd1);
        check("trap_req",   imem_req,    64'd0);
        check("trap_valid", inst_valid,  64'd0);
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        tick;
        imem_ack = 1'b0;
        check("halt_valid", inst_valid,  64'd0);
        check("halt_req",   imem_req,    64'd0);
        check("halt_fault", fetch_fault, 64'd1);
        redirect = 1'b1; redirect_pc = 64'h200;
        tick;
        redirect = 1'b0;
        check("clear_fault", fetch_fault, 64'd0);
        check("clear_req",   imem_req,    64'd0);
        tick;
        check("resume_req",  imem_req,  64'd1);
        check("resume_addr", imem_addr, 64'h200);
`else
        check("align_fault", fetch_fault, 64'd0);
        check("align_req",   imem_req,    64'd0);
        check("align_valid", inst_valid,  64'd0);
        tick;
        check("align_next_req",  imem_req,  64'd1);
        check("align_next_addr", imem_addr, 64'h100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
